instr_align_buffer: RTL and testbench

//  Fetch-side alignment stage that sits directly upstream of the C-extension decompressor.

---
 rtl/instr_align_if.sv | 32 +++
 rtl/instr_align_buffer.sv | 94 +++++++++
 tb/tb_instr_align_buffer.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_align_if.sv
// +----------------------------------------------------------------------------+
// | instr_align_if : fetch-word / instruction handshake bundle for the         |
// |                  instruction alignment buffer                              |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

interface instr_align_if;
  logic        fw_valid;
  logic        fw_ready;
  logic [31:0] fw_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_comp;
  logic [31:0] out_pc;

  // master = fetch unit plus instruction consumer; slave = the alignment buffer
  modport master (
    output fw_valid, fw_data, redirect, redirect_pc, out_ready,
    input  fw_ready, out_valid, out_instr, out_comp, out_pc
  );

  modport slave (
    input  fw_valid, fw_data, redirect, redirect_pc, out_ready,
    output fw_ready, out_valid, out_instr, out_comp, out_pc
  );
endinterface

`default_nettype wire

// File: rtl/instr_align_buffer.sv
// +----------------------------------------------------------------------------+
// | instr_align_buffer : splits aligned 32-bit fetch words into 16-bit         |
// |                      compressed parcels and (possibly straddling) 32-bit   |
// |                      instructions, each tagged with its PC                 |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module instr_align_buffer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_align_if.slave  bus
);

  logic [15:0] r_hw [4];
  logic [2:0]  r_count;
  logic        r_skip;
  logic [31:0] r_pc;

  logic        w_need_two;
  logic [2:0]  w_need;
  logic        w_pop;
  logic        w_push;
  logic [2:0]  w_pop_n;
  logic [2:0]  w_push_n;
  logic [2:0]  w_rem;
  logic [15:0] w_hw_nxt [4];

  assign w_need_two = (r_hw[0][1:0] == 2'b11);
  assign w_need     = w_need_two ? 3'd2 : 3'd1;

  assign bus.out_valid = (r_count >= w_need) && !bus.redirect;
  assign bus.fw_ready  = (r_count <= 3'd2) && !bus.redirect;
  assign bus.out_instr = w_need_two ? {r_hw[1], r_hw[0]} : {16'h0000, r_hw[0]};
  assign bus.out_comp  = !w_need_two;
  assign bus.out_pc    = r_pc;

  assign w_pop    = bus.out_valid && bus.out_ready;
  assign w_push   = bus.fw_valid && bus.fw_ready;
  assign w_pop_n  = w_pop ? w_need : 3'd0;
  assign w_push_n = w_push ? (r_skip ? 3'd1 : 3'd2) : 3'd0;
  assign w_rem    = r_count - w_pop_n;

  // Shift out the consumed halfwords first, then append the new ones behind
  // whatever is left; push is only allowed at count<=2 so rem+1 stays in range.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_hw_nxt[i] = r_hw[i];
      if ((3'(i) + w_pop_n) <= 3'd3) begin
        w_hw_nxt[i] = r_hw[2'(3'(i) + w_pop_n)];
      end
      if (w_push) begin
        if (3'(i) == w_rem) begin
          w_hw_nxt[i] = r_skip ? bus.fw_data[31:16] : bus.fw_data[15:0];
        end
        if (!r_skip && (3'(i) == (w_rem + 3'd1))) begin
          w_hw_nxt[i] = bus.fw_data[31:16];
        end
      end
    end
  end

  // Halfword payload carries no reset; validity is tracked by r_count alone.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      r_hw[i] <= w_hw_nxt[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 3'd0;
      r_skip  <= 1'b0;
      r_pc    <= RESET_PC;
    end else if (bus.redirect) begin
      r_count <= 3'd0;
      r_skip  <= bus.redirect_pc[1];
      r_pc    <= {bus.redirect_pc[31:1], 1'b0};
    end else begin
      r_count <= w_rem + w_push_n;
      if (w_push) begin
        r_skip <= 1'b0;
      end
      if (w_pop) begin
        r_pc <= r_pc + (w_need_two ? 32'd4 : 32'd2);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_align_buffer.sv
// +----------------------------------------------------------------------------+
// | tb_instr_align_buffer : vector table + scoreboard bench for the            |
// |                         instruction alignment buffer                       |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_instr_align_buffer;

  typedef struct {
    logic [31:0] word;
    int          n;
    logic [31:0] i0;
    logic        c0;
    logic [31:0] p0;
    logic [31:0] i1;
    logic        c1;
    logic [31:0] p1;
  } vec_t;

  typedef struct packed {
    logic [31:0] instr;
    logic        comp;
    logic [31:0] pc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic sb_en;
  logic rnd_ready;
  exp_t q[$];
  vec_t vecs[8];

  instr_align_if bus();
  instr_align_if bw();

  instr_align_buffer u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  instr_align_buffer #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every handshake pops and compares one expected record
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_en && bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_out", bus.out_instr, 32'hDEAD_BEEF);
        end else begin
          e = q.pop_front();
          chk("sb_instr", bus.out_instr, e.instr);
          chk("sb_comp", {31'd0, bus.out_comp}, {31'd0, e.comp});
          chk("sb_pc", bus.out_pc, e.pc);
        end
      end
    end
  end

  task automatic send_word(input logic [31:0] w);
    int   t;
    logic acc;
    t = 0;
    bus.fw_valid = 1'b1;
    bus.fw_data  = w;
    forever begin
      @(negedge clk);
      acc = bus.fw_ready;
      @(posedge clk);
      #1;
      if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
      if (acc) break;
      t++;
      if (t > 200) begin
        chk("fw_accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    bus.fw_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    bus.out_ready = 1'b1;
    while (q.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain_empty", q.size(), 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] held_instr;
    checks = 0;
    errors = 0;
    sb_en = 1'b0;
    rnd_ready = 1'b0;

    vecs[0] = '{32'h0513_4501, 1, 32'h0000_4501, 1'b1, 32'h00, 32'h0, 1'b0, 32'h0};
    vecs[1] = '{32'h4505_00A0, 2, 32'h00A0_0513, 1'b0, 32'h02, 32'h0000_4505, 1'b1, 32'h06};
    vecs[2] = '{32'h4505_4501, 2, 32'h0000_4501, 1'b1, 32'h08, 32'h0000_4505, 1'b1, 32'h0A};
    vecs[3] = '{32'h0013_0293, 1, 32'h0013_0293, 1'b0, 32'h0C, 32'h0, 1'b0, 32'h0};
    vecs[4] = '{32'h00B3_4581, 1, 32'h0000_4581, 1'b1, 32'h10, 32'h0, 1'b0, 32'h0};
    vecs[5] = '{32'h8082_0040, 2, 32'h0040_00B3, 1'b0, 32'h12, 32'h0000_8082, 1'b1, 32'h16};
    vecs[6] = '{32'hFFFF_0001, 1, 32'h0000_0001, 1'b1, 32'h18, 32'h0, 1'b0, 32'h0};
    vecs[7] = '{32'h0001_1234, 2, 32'h1234_FFFF, 1'b0, 32'h1A, 32'h0000_0001, 1'b1, 32'h1E};

    bus.fw_valid = 1'b0; bus.fw_data = 32'h0; bus.redirect = 1'b0;
    bus.redirect_pc = 32'h0; bus.out_ready = 1'b0;
    bw.fw_valid = 1'b0; bw.fw_data = 32'h0; bw.redirect = 1'b0;
    bw.redirect_pc = 32'h0; bw.out_ready = 1'b0;

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_fw_ready", {31'd0, bus.fw_ready}, 32'd1);
    chk("rst_out_pc", bus.out_pc, 32'h0);
    chk("rst_wrap_pc", bw.out_pc, 32'hFFFF_FFFC);

    // Vector stream with random consumer backpressure
    sb_en = 1'b1;
    rnd_ready = 1'b1;
    tick();
    for (int v = 0; v < 8; v++) begin
      q.push_back('{vecs[v].i0, vecs[v].c0, vecs[v].p0});
      if (vecs[v].n == 2) q.push_back('{vecs[v].i1, vecs[v].c1, vecs[v].p1});
      send_word(vecs[v].word);
    end
    rnd_ready = 1'b0;
    drain();

    // Redirect to a mid-word PC: lower halfword of the first word is skipped
    bus.out_ready = 1'b0;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0000_0102;
    tick();
    bus.redirect = 1'b0;
    bus.out_ready = 1'b1;
    q.push_back('{32'h0000_9002, 1'b1, 32'h0000_0102});
    send_word(32'h9002_1234);
    repeat (5) tick();
    chk("skip_only_one", q.size(), 32'd0);
    chk("skip_empty_after", {31'd0, bus.out_valid}, 32'd0);
    sb_en = 1'b0;

    // Fill to full with consumer stalled; head must hold
    bus.out_ready = 1'b0;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0;
    tick();
    bus.redirect = 1'b0;
    bus.fw_valid = 1'b1;
    bus.fw_data = 32'h4505_4501;
    @(negedge clk);
    chk("fill_ready0", {31'd0, bus.fw_ready}, 32'd1);
    chk("fill_valid0", {31'd0, bus.out_valid}, 32'd0);
    tick();
    @(negedge clk);
    chk("fill_ready2", {31'd0, bus.fw_ready}, 32'd1);
    chk("fill_valid2", {31'd0, bus.out_valid}, 32'd1);
    tick();
    @(negedge clk);
    chk("full_ready", {31'd0, bus.fw_ready}, 32'd0);
    chk("full_instr", bus.out_instr, 32'h0000_4501);
    chk("full_comp", {31'd0, bus.out_comp}, 32'd1);
    chk("full_pc", bus.out_pc, 32'h0);
    held_instr = bus.out_instr;
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      chk("hold_instr", bus.out_instr, held_instr);
      chk("hold_pc", bus.out_pc, 32'h0);
      chk("hold_ready", {31'd0, bus.fw_ready}, 32'd0);
    end

    // Redirect beats simultaneous push and pop
    tick();
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0000_0201;
    bus.fw_data = 32'h1111_1111;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("redir_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("redir_fw_ready", {31'd0, bus.fw_ready}, 32'd0);
    tick();
    bus.redirect = 1'b0;
    bus.fw_valid = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("post_redir_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("post_redir_pc", bus.out_pc, 32'h0000_0200);
    chk("post_redir_ready", {31'd0, bus.fw_ready}, 32'd1);
    tick();
    bus.fw_valid = 1'b1;
    bus.fw_data = 32'h0000_4509;
    tick();
    bus.fw_valid = 1'b0;
    @(negedge clk);
    chk("post_redir_instr", bus.out_instr, 32'h0000_4509);
    chk("post_redir_pc2", bus.out_pc, 32'h0000_0200);

    // Asynchronous reset in the middle of a held instruction
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("after_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("after_rst_pc", bus.out_pc, 32'h0);
    chk("after_rst_ready", {31'd0, bus.fw_ready}, 32'd1);
    tick();
    bus.fw_valid = 1'b1;
    bus.fw_data = 32'h0513_4501;
    tick();
    bus.fw_valid = 1'b0;
    @(negedge clk);
    chk("restart_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("restart_instr", bus.out_instr, 32'h0000_4501);
    chk("restart_pc", bus.out_pc, 32'h0);

    // PC wrap on the second instance
    tick();
    bw.fw_valid = 1'b1;
    bw.fw_data = 32'h4505_4501;
    bw.out_ready = 1'b1;
    @(negedge clk);
    chk("wrap_accept", {31'd0, bw.fw_ready}, 32'd1);
    tick();
    bw.fw_valid = 1'b0;
    @(negedge clk);
    chk("wrap_instr0", bw.out_instr, 32'h0000_4501);
    chk("wrap_pc0", bw.out_pc, 32'hFFFF_FFFC);
    tick();
    @(negedge clk);
    chk("wrap_instr1", bw.out_instr, 32'h0000_4505);
    chk("wrap_pc1", bw.out_pc, 32'hFFFF_FFFE);
    tick();
    @(negedge clk);
    chk("wrap_empty", {31'd0, bw.out_valid}, 32'd0);
    chk("wrap_pc2", bw.out_pc, 32'h0);

    chk("sb_leftover", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
